pushbutton_conditioner: RTL and testbench

Conditions a raw, bouncing, active-low push button into clean single-clock-domain control signals. Outputs are a debounced level, press/release strobes and a long-press detector. The long-press output reset_req_n drives the reset_in_n input of the downstream reset generator, so a sustained press issues a system reset. Short presses are only user strobes.

---
 rtl/pushbutton_conditioner.sv | 133 +++++++++++++
 tb/tb_pushbutton_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
// Purpose: turn a raw, bouncing, active-low push button into a debounced level, press/release strobes and a long-press reset request.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES cycles from a clean raw edge to pressed/press_pulse/release_pulse; long press HOLD_CYCLES after the press is accepted.
// Backpressure: none; all outputs are free-running registered levels and single-cycle strobes.
module pushbutton_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic reset_req_n
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  // Debounce finishes on the sample that brings the run length to DEBOUNCE_CYCLES,
  // so the comparison is against the count held before that sample.
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [DCW-1:0]         dbc_cnt;
  logic [HCW-1:0]         hold_cnt;
  logic                   dbc_done;
  logic                   release_accept;

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign dbc_done = (dbc_cnt == DEB_LAST);

  // A release is accepted this cycle when the debounce run completes while held.
  assign release_accept = btn_s && dbc_done &&
                          ((state == S_PRESSED) || (state == S_RELEASE_WAIT));

  // Synchronizer chain; resets to the released level so a held button must re-qualify.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
    end
  end

  // Debounce / hold state machine with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      dbc_cnt          <= '0;
      hold_cnt         <= '0;
      pressed          <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      reset_req_n      <= 1'b1;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;

      case (state)
        // Released side: IDLE with a zero count behaves as the first debounce step,
        // which lets DEBOUNCE_CYCLES=1 accept a single low sample directly.
        S_IDLE, S_PRESS_WAIT: begin
          if (!btn_s) begin
            if (dbc_done) begin
              state       <= S_PRESSED;
              dbc_cnt     <= '0;
              hold_cnt    <= '0;
              pressed     <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              state   <= S_PRESS_WAIT;
              dbc_cnt <= dbc_cnt + DCW'(1);
            end
          end else begin
            state   <= S_IDLE;
            dbc_cnt <= '0;
          end
        end

        // Held side: the hold counter keeps running through release glitches.
        S_PRESSED, S_RELEASE_WAIT: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
          // Suppress a long press that would coincide with the accepted release,
          // so reset_req_n never falls after pressed has dropped.
          if ((hold_cnt == HOLD_LAST) && !release_accept) begin
            long_press_pulse <= 1'b1;
            reset_req_n      <= 1'b0;
          end

          if (btn_s) begin
            if (dbc_done) begin
              state         <= S_IDLE;
              dbc_cnt       <= '0;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
              reset_req_n   <= 1'b1;
            end else begin
              state   <= S_RELEASE_WAIT;
              dbc_cnt <= dbc_cnt + DCW'(1);
            end
          end else begin
            state   <= S_PRESSED;
            dbc_cnt <= '0;
          end
        end

        default: begin
          state   <= S_IDLE;
          dbc_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Purpose: directed bench for pushbutton_conditioner with a cycle-level behavioural model and literal checkpoints.
// Latency: checks sample 1-2 ns after each rising edge and at every falling edge.
// Backpressure: not applicable.
module tb_pushbutton_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int H = 20;

  logic clock;
  logic reset_n;
  logic button_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;
  logic reset_req_n;

  int n_cmp;
  int n_bad;
  bit cmp_en;

  pushbutton_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .button_n        (button_n),
    .pressed         (pressed),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .reset_req_n     (reset_req_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: the button as seen by the state logic is the raw input
  // delayed by S edges; the level flips once the last D seen samples all disagree
  // with it; a press ages one per edge and is declared long at age H.
  bit pipe [S];
  bit win  [$];
  bit m_level, m_pp, m_rp, m_lp, m_req;
  int m_age;

  always @(posedge clock or negedge reset_n) begin
    bit smp;
    bit all_diff;
    bit rel;
    if (!reset_n) begin
      for (int i = 0; i < S; i++) pipe[i] = 1'b1;
      win.delete();
      m_level = 1'b0;
      m_pp    = 1'b0;
      m_rp    = 1'b0;
      m_lp    = 1'b0;
      m_req   = 1'b1;
      m_age   = 0;
    end else begin
      smp = pipe[S-1];
      for (int i = S-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = button_n;

      win.push_back(smp);
      if (win.size() > D) void'(win.pop_front());
      all_diff = (win.size() == D);
      foreach (win[i]) if (win[i] != m_level) all_diff = 1'b0;

      m_pp = 1'b0;
      m_rp = 1'b0;
      m_lp = 1'b0;
      rel  = m_level && all_diff;
      if (m_level) begin
        m_age++;
        if (m_age == H && !rel) begin
          m_lp  = 1'b1;
          m_req = 1'b0;
        end
      end
      if (all_diff) begin
        if (!m_level) begin
          m_level = 1'b1;
          m_pp    = 1'b1;
          m_age   = 0;
        end else begin
          m_level = 1'b0;
          m_rp    = 1'b1;
          m_req   = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [4:0] got, want;
    if (cmp_en) begin
      got  = {pressed, press_pulse, release_pulse, long_press_pulse, reset_req_n};
      want = {m_level, m_pp, m_rp, m_lp, m_req};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL model t=%0t: got {pressed,pp,rp,lp,req}=%b, required %b", $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %b, required %b", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cmp_en   = 1'b0;
    reset_n  = 1'b1;
    button_n = 1'b1;

    // Scenario 1: reset with the button released.
    #2 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    chk("s1 rst pressed", 0, pressed, 1'b0);
    chk("s1 rst req", 0, reset_req_n, 1'b1);
    chk("s1 rst pulses", 0, press_pulse | release_pulse | long_press_pulse, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("s1 in-rst req", k, reset_req_n, 1'b1);
      chk("s1 in-rst pressed", k, pressed, 1'b0);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("s1 post req", k, reset_req_n, 1'b1);
      chk("s1 post pressed", k, pressed, 1'b0);
      chk("s1 post pulses", k, press_pulse | release_pulse | long_press_pulse, 1'b0);
    end

    // Scenario 2: clean press held 10 cycles.
    for (int k = 0; k <= 30; k++) begin
      step();
      button_n = (k < 10) ? 1'b0 : 1'b1;
      #1;
      if (k <= 10) begin
        chk("s2 press_pulse", k, press_pulse, k == 6);
        chk("s2 pressed", k, pressed, k >= 6);
        chk("s2 long", k, long_press_pulse, 1'b0);
        chk("s2 req", k, reset_req_n, 1'b1);
      end
      if (k == 16) chk("s2 release_pulse", k, release_pulse, 1'b1);
    end

    // Scenario 3: bounce then a clean press at cycle 20.
    for (int k = 0; k <= 45; k++) begin
      step();
      button_n = (k < 3) ? 1'b0 : (k < 5) ? 1'b1 : (k < 8) ? 1'b0 :
                 (k < 20) ? 1'b1 : (k < 30) ? 1'b0 : 1'b1;
      #1;
      chk("s3 press_pulse", k, press_pulse, k == 26);
      chk("s3 pressed", k, pressed, (k >= 26) && (k < 36));
      chk("s3 release_pulse", k, release_pulse, k == 36);
      chk("s3 long", k, long_press_pulse, 1'b0);
    end

    // Scenario 4: long press for 40 cycles.
    for (int k = 0; k <= 55; k++) begin
      step();
      button_n = (k < 40) ? 1'b0 : 1'b1;
      #1;
      chk("s4 long", k, long_press_pulse, k == 26);
      chk("s4 req", k, reset_req_n, !((k >= 26) && (k < 46)));
      chk("s4 release_pulse", k, release_pulse, k == 46);
      chk("s4 pressed", k, pressed, (k >= 6) && (k < 46));
    end

    // Scenario 5: release glitch does not restart the hold.
    for (int k = 0; k <= 45; k++) begin
      step();
      button_n = ((k >= 10) && (k < 13)) || (k >= 30);
      #1;
      chk("s5 pressed", k, pressed, (k >= 6) && (k < 36));
      chk("s5 release_pulse", k, release_pulse, k == 36);
      chk("s5 long", k, long_press_pulse, k == 26);
      chk("s5 req", k, reset_req_n, !((k >= 26) && (k < 36)));
    end

    // Scenario 6: reset mid long press, button still held afterwards.
    for (int k = 0; k <= 80; k++) begin
      step();
      button_n = (k < 66) ? 1'b0 : 1'b1;
      if (k == 30) reset_n = 1'b0;
      if (k == 35) reset_n = 1'b1;
      #1;
      if (k == 30) begin
        chk("s6 async req", k, reset_req_n, 1'b1);
        chk("s6 async pressed", k, pressed, 1'b0);
      end
      chk("s6 press_pulse", k, press_pulse, (k == 6) || (k == 41));
      chk("s6 long", k, long_press_pulse, (k == 26) || (k == 61));
      chk("s6 req", k, reset_req_n, !(((k >= 26) && (k < 30)) || ((k >= 61) && (k < 72))));
      chk("s6 pressed", k, pressed, ((k >= 6) && (k < 30)) || ((k >= 41) && (k < 72)));
      chk("s6 release_pulse", k, release_pulse, k == 72);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
